// File: rtl/jk_bank_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : jka_pkg                                                           |
// | Brief  : Shared types and constants for the JK bank arbiter slice.         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package jka_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  // Command encoding is {j, k}
  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_RST  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_TGL  = 2'b11;

  localparam int TCNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/jk_bank_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : jk_bank_arbiter_if                                                |
// | Brief  : Requester-side command bus and bank state of the JK bank arbiter. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface jk_bank_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int NBITS = 8
);
  localparam int AW = $clog2(NBITS);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    j;
  logic [NREQ-1:0]    k;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0]    gnt;
  logic               done;
  logic               err;
  logic               busy;
  logic [NBITS-1:0]   q;

  modport master (output req, j, k, addr, input gnt, done, err, busy, q);
  modport slave  (input req, j, k, addr, output gnt, done, err, busy, q);

endinterface
`default_nettype wire

// File: rtl/jk_bank_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : jk_rr_arbiter                                                     |
// | Brief  : Round-robin pick of the first request at or after the pointer.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module jk_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] winner,
  output logic            valid
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic          w_found;
  int            w_pos;

  always_comb begin
    w_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int off = 0; off < NREQ; off++) begin
      w_pos = (int'(r_ptr) + off) % NREQ;
      if (!w_found && req[w_pos]) begin
        w_found = 1'b1;
        w_idx   = PW'(w_pos);
      end
    end
  end

  assign valid  = w_found;
  assign winner = w_found ? (NREQ'(1) << w_idx) : '0;

  // The winner's successor becomes highest priority for the next pick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_ptr <= '0;
    else if (advance && w_found)
      r_ptr <= PW'((int'(w_idx) + 1) % NREQ);
  end

endmodule
`default_nettype wire

// File: rtl/jk_bank_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : jk_bank_arbiter                                                   |
// | Brief  : Round-robin shared JK flip-flop bank; optional JKA_TOGGLE_CNT_EN  |
// |          adds a saturating count of applied toggles.                       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module jk_bank_arbiter
  import jka_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int NBITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  jk_bank_arbiter_if.slave  bus
`ifdef JKA_TOGGLE_CNT_EN
  ,
  output logic [TCNT_W-1:0] toggle_cnt
`endif
);
  localparam int AW = $clog2(NBITS);

  state_t           r_state;
  logic [NREQ-1:0]  r_gnt;
  logic             r_done;
  logic             r_err;
  logic             r_busy;
  logic [NBITS-1:0] r_q;
  logic             r_j;
  logic             r_k;
  logic [AW-1:0]    r_addr;

  logic [NREQ-1:0]  w_winner;
  logic             w_valid;
  logic             w_sel_j;
  logic             w_sel_k;
  logic [AW-1:0]    w_sel_addr;
  logic             w_addr_ok;

  jk_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.req),
    .advance (r_state == IDLE),
    .winner  (w_winner),
    .valid   (w_valid)
  );

  always_comb begin
    w_sel_j    = 1'b0;
    w_sel_k    = 1'b0;
    w_sel_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner[i]) begin
        w_sel_j    = bus.j[i];
        w_sel_k    = bus.k[i];
        w_sel_addr = bus.addr[i*AW +: AW];
      end
    end
  end

  // Non power-of-two banks leave addresses that decode to nothing
  assign w_addr_ok = (int'(r_addr) < NBITS);

`ifdef JKA_TOGGLE_CNT_EN
  logic [TCNT_W-1:0] r_tcnt;
  assign toggle_cnt = r_tcnt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_q     <= '0;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
      r_addr  <= '0;
`ifdef JKA_TOGGLE_CNT_EN
      r_tcnt  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (w_valid) begin
            r_gnt   <= w_winner;
            r_j     <= w_sel_j;
            r_k     <= w_sel_k;
            r_addr  <= w_sel_addr;
            r_busy  <= 1'b1;
            r_state <= GRANT;
          end else begin
            r_gnt  <= '0;
            r_busy <= 1'b0;
          end
        end
        GRANT: begin
          r_gnt   <= '0;
          r_done  <= 1'b1;
          r_err   <= ~w_addr_ok;
          r_state <= ACK;
          for (int b = 0; b < NBITS; b++) begin
            if (w_addr_ok && (r_addr == AW'(b))) begin
              case ({r_j, r_k})
                CMD_RST: r_q[b] <= 1'b0;
                CMD_SET: r_q[b] <= 1'b1;
                CMD_TGL: r_q[b] <= ~r_q[b];
                default: ;
              endcase
            end
          end
`ifdef JKA_TOGGLE_CNT_EN
          if (w_addr_ok && ({r_j, r_k} == CMD_TGL) && (r_tcnt != '1))
            r_tcnt <= r_tcnt + 1'b1;
`endif
        end
        ACK: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.done = r_done;
  assign bus.err  = r_err;
  assign bus.busy = r_busy;
  assign bus.q    = r_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_jk_bank_arbiter                                                |
// | Brief  : Directed bench for jk_bank_arbiter (8-bit and 6-bit banks).       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_jk_bank_arbiter;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  jk_bank_arbiter_if #(.NREQ(2), .NBITS(8)) b8 ();
  jk_bank_arbiter_if #(.NREQ(2), .NBITS(6)) b6 ();

`ifdef JKA_TOGGLE_CNT_EN
  logic [15:0] tc8;
  logic [15:0] tc6;
`endif

  jk_bank_arbiter #(.NREQ(2), .NBITS(8)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8.slave)
`ifdef JKA_TOGGLE_CNT_EN
    , .toggle_cnt (tc8)
`endif
  );

  jk_bank_arbiter #(.NREQ(2), .NBITS(6)) u_dut6 (
    .clk   (clk),
    .reset (reset),
    .bus   (b6.slave)
`ifdef JKA_TOGGLE_CNT_EN
    , .toggle_cnt (tc6)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] gnt_of(input int d);
    return (d == 0) ? 64'(b8.gnt) : 64'(b6.gnt);
  endfunction
  function automatic logic [63:0] done_of(input int d);
    return (d == 0) ? 64'(b8.done) : 64'(b6.done);
  endfunction
  function automatic logic [63:0] err_of(input int d);
    return (d == 0) ? 64'(b8.err) : 64'(b6.err);
  endfunction
  function automatic logic [63:0] busy_of(input int d);
    return (d == 0) ? 64'(b8.busy) : 64'(b6.busy);
  endfunction
  function automatic logic [63:0] q_of(input int d);
    return (d == 0) ? 64'(b8.q) : 64'(b6.q);
  endfunction

  task automatic drive(input int d, input int r, input bit jj, input bit kk, input int a);
    logic [2:0] a3;
    a3 = a[2:0];
    if (d == 0) begin
      b8.req = '0;
      b8.req[r] = 1'b1;
      b8.j[r] = jj;
      b8.k[r] = kk;
      b8.addr[r*3 +: 3] = a3;
    end else begin
      b6.req = '0;
      b6.req[r] = 1'b1;
      b6.j[r] = jj;
      b6.k[r] = kk;
      b6.addr[r*3 +: 3] = a3;
    end
  endtask

  task automatic clear_req(input int d);
    if (d == 0) b8.req = '0;
    else        b6.req = '0;
  endtask

  // One full command from a lone requester: gnt, then done with new q, then idle
  task automatic cmd(input int d, input int r, input bit jj, input bit kk, input int a,
                     input bit exp_err, input logic [7:0] exp_q);
    drive(d, r, jj, kk, a);
    cyc();
    chk("gnt", gnt_of(d), 64'(1 << r));
    chk("busy_grant", busy_of(d), 64'd1);
    chk("done_grant", done_of(d), 64'd0);
    clear_req(d);
    cyc();
    chk("done_ack", done_of(d), 64'd1);
    chk("err_ack", err_of(d), 64'(exp_err));
    chk("q_ack", q_of(d), 64'(exp_q));
    chk("gnt_ack", gnt_of(d), 64'd0);
    cyc();
    chk("done_idle", done_of(d), 64'd0);
    chk("busy_idle", busy_of(d), 64'd0);
  endtask

  initial begin
    reset   = 1'b0;
    b8.req  = 2'b11;
    b8.j    = '0;
    b8.k    = '0;
    b8.addr = '0;
    b6.req  = '0;
    b6.j    = '0;
    b6.k    = '0;
    b6.addr = '0;

    // Reset held with requests pending
    repeat (3) cyc();
    chk("rst_q", q_of(0), 64'd0);
    chk("rst_gnt", gnt_of(0), 64'd0);
    chk("rst_done", done_of(0), 64'd0);
    chk("rst_busy", busy_of(0), 64'd0);
    reset = 1'b1;
    cyc();
    chk("rel_gnt", gnt_of(0), 64'd1);
    b8.req = '0;
    cyc();
    chk("rel_done", done_of(0), 64'd1);
    chk("rel_q", q_of(0), 64'd0);
    cyc();
    chk("rel_idle", done_of(0), 64'd0);

    // Single commands
    cmd(0, 0, 1'b1, 1'b0, 3, 1'b0, 8'h08);
    cmd(0, 0, 1'b1, 1'b1, 3, 1'b0, 8'h00);
    cmd(0, 0, 1'b0, 1'b1, 0, 1'b0, 8'h00);
    cmd(0, 0, 1'b0, 1'b0, 0, 1'b0, 8'h00);
    cmd(0, 1, 1'b1, 1'b0, 7, 1'b0, 8'h80);
    cmd(0, 1, 1'b1, 1'b1, 7, 1'b0, 8'h00);

    // Contention: both toggle bit 5, strict alternation, done every 3 cycles
    b8.req  = 2'b11;
    b8.j    = 2'b11;
    b8.k    = 2'b11;
    b8.addr = {3'd5, 3'd5};
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("cont_gnt", gnt_of(0), (i % 2 == 0) ? 64'd1 : 64'd2);
      chk("cont_done0", done_of(0), 64'd0);
      if (i == 3) b8.req = '0;
      cyc();
      chk("cont_done", done_of(0), 64'd1);
      chk("cont_q", q_of(0), (i % 2 == 0) ? 64'h20 : 64'h00);
      cyc();
      chk("cont_done_low", done_of(0), 64'd0);
    end
    cyc();
    chk("cont_quiet", gnt_of(0), 64'd0);

    // Out-of-range address on a 6-bit bank, then a valid one
    cmd(1, 0, 1'b1, 1'b0, 7, 1'b1, 8'h00);
    cmd(1, 1, 1'b1, 1'b0, 5, 1'b0, 8'h20);

    // Reset during GRANT abandons the pending set
    cmd(0, 0, 1'b1, 1'b0, 6, 1'b0, 8'h40);
    drive(0, 0, 1'b1, 1'b0, 2);
    cyc();
    chk("mid_gnt", gnt_of(0), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_q", q_of(0), 64'd0);
    chk("mid_gnt_clr", gnt_of(0), 64'd0);
    chk("mid_busy", busy_of(0), 64'd0);
    clear_req(0);
    cyc();
    reset = 1'b1;
    cyc();
    chk("mid_done", done_of(0), 64'd0);
    chk("mid_q_after", q_of(0), 64'd0);
    chk("mid_q6", q_of(1), 64'd0);

`ifdef JKA_TOGGLE_CNT_EN
    chk("tc_reset", 64'(tc6), 64'd0);
    cmd(1, 0, 1'b1, 1'b1, 1, 1'b0, 8'h02);
    cmd(1, 0, 1'b1, 1'b1, 1, 1'b0, 8'h00);
    cmd(1, 0, 1'b1, 1'b1, 1, 1'b0, 8'h02);
    cmd(1, 0, 1'b1, 1'b0, 4, 1'b0, 8'h12);
    cmd(1, 0, 1'b1, 1'b1, 7, 1'b1, 8'h12);
    chk("tc_count", 64'(tc6), 64'd3);
    chk("tc8_idle", 64'(tc8), 64'd0);
    force u_dut6.r_tcnt = 16'hFFFE;
    #1;
    release u_dut6.r_tcnt;
    cmd(1, 0, 1'b1, 1'b1, 1, 1'b0, 8'h10);
    chk("tc_top", 64'(tc6), 64'hFFFF);
    cmd(1, 0, 1'b1, 1'b1, 1, 1'b0, 8'h12);
    chk("tc_sat", 64'(tc6), 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
